// File: rtl/mem_pkg.sv
// Shared widths, FSM encoding and the EX/MEM record for the MEM stage.
package mem_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Everything the EX/MEM pipeline register captures from execute.
    typedef struct packed {
        logic              valid;
        logic              regWrite;
        logic              memtoReg;
        logic              memWrite;
        logic              memRead;
        logic              branch;
        logic [DATA_W-1:0] adder2;
        logic              aluZero;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] rdData;
        logic [REG_W-1:0]  writeReg;
    } exmem_t;

    // A captured instruction needs the data memory when it is real and
    // either reads or writes (both set is handled as a write elsewhere).
    function automatic logic is_mem_op(input exmem_t e);
        return e.valid & (e.memRead | e.memWrite);
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on retire, inserts a bubble while stalled.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_retire,
    input  logic              i_abort,
    input  logic              i_load_rdata,
    input  logic              i_valid,
    input  logic              i_regWrite,
    input  logic              i_memtoReg,
    input  logic [DATA_W-1:0] i_aluResult,
    input  logic [REG_W-1:0]  i_writeReg,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_wb_valid,
    output logic              o_regWrite,
    output logic              o_memtoReg,
    output logic [DATA_W-1:0] o_aluResult,
    output logic [DATA_W-1:0] o_memData,
    output logic [REG_W-1:0]  o_writeReg
);

    logic              r_wb_valid;
    logic              r_regWrite;
    logic              r_memtoReg;
    logic [DATA_W-1:0] r_aluResult;
    logic [DATA_W-1:0] r_memData;
    logic [REG_W-1:0]  r_writeReg;

    // Retire copies the instruction forward; an aborted access never writes
    // the register file and delivers zero data. Non-retire cycles only
    // drop the valid bit so downstream sees a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_valid  <= 1'b0;
            r_regWrite  <= 1'b0;
            r_memtoReg  <= 1'b0;
            r_aluResult <= '0;
            r_memData   <= '0;
            r_writeReg  <= '0;
        end else if (i_retire) begin
            r_wb_valid  <= i_valid;
            r_regWrite  <= i_regWrite & ~i_abort;
            r_memtoReg  <= i_memtoReg;
            r_aluResult <= i_aluResult;
            r_writeReg  <= i_writeReg;
            if (i_abort) begin
                r_memData <= '0;
            end else if (i_load_rdata) begin
                r_memData <= i_rdata;
            end
        end else begin
            r_wb_valid <= 1'b0;
        end
    end

    assign o_wb_valid  = r_wb_valid;
    assign o_regWrite  = r_regWrite;
    assign o_memtoReg  = r_memtoReg;
    assign o_aluResult = r_aluResult;
    assign o_memData   = r_memData;
    assign o_writeReg  = r_writeReg;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, branch resolution, req/ack data-memory
// handshake with timeout, and the MEM/WB register feeding writeback.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              regWrite3,
    input  logic              memtoReg3,
    input  logic              memWrite3,
    input  logic              memRead3,
    input  logic              branch3,
    input  logic [DATA_W-1:0] adder2,
    input  logic              aluZero,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [DATA_W-1:0] rdData2_3,
    input  logic [REG_W-1:0]  mux3Out,
    output logic              stall,
    output logic              pcSrc,
    output logic [DATA_W-1:0] branchTarget,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              regWrite4,
    output logic              memtoReg4,
    output logic [DATA_W-1:0] aluResult4,
    output logic [DATA_W-1:0] memData4,
    output logic [REG_W-1:0]  writeReg4,
    output logic              mem_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     r_state, w_state_next;
    logic [7:0] r_cnt, w_cnt_next;
    exmem_t     r_exmem, w_exmem_in;
    logic       r_mem_err;

    logic w_in_access, w_last, w_stall, w_abort, w_ack;
    logic w_memop, w_in_memop, w_load_rdata;

    assign w_exmem_in = '{
        valid:     ex_valid,
        regWrite:  regWrite3,
        memtoReg:  memtoReg3,
        memWrite:  memWrite3,
        memRead:   memRead3,
        branch:    branch3,
        adder2:    adder2,
        aluZero:   aluZero,
        aluResult: aluResult,
        rdData:    rdData2_3,
        writeReg:  mux3Out
    };

    assign w_memop     = is_mem_op(r_exmem);
    assign w_in_memop  = is_mem_op(w_exmem_in);
    assign w_in_access = (r_state == ACCESS);
    assign w_last      = (r_cnt == CNT_LAST);
    assign w_ack       = w_in_access & dmem_ack;
    assign w_abort     = w_in_access & ~dmem_ack & w_last;
    assign w_stall     = w_in_access & ~dmem_ack & ~w_last;
    // Read-and-write together counts as a write, so only a pure read loads data.
    assign w_load_rdata = w_ack & r_exmem.memRead & ~r_exmem.memWrite;

    // EX/MEM register advances whenever the stage is not stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exmem <= '0;
        end else if (!w_stall) begin
            r_exmem <= w_exmem_in;
        end
    end

    // FSM state and cycles-waited counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state follows whatever EX/MEM captures on a non-stalled edge, so
    // back-to-back memory ops stay in ACCESS without a bubble.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_in_memop) begin
                    w_state_next = ACCESS;
                    w_cnt_next   = '0;
                end
            end
            ACCESS: begin
                dmem_req   = 1'b1;
                dmem_we    = r_exmem.memWrite;
                dmem_addr  = r_exmem.aluResult;
                dmem_wdata = r_exmem.rdData;
                if (w_stall) begin
                    w_cnt_next = r_cnt + 8'd1;
                end else begin
                    w_state_next = w_in_memop ? ACCESS : IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_err <= 1'b0;
        end else if (w_abort) begin
            r_mem_err <= 1'b1;
        end
    end

    assign stall        = w_stall;
    assign mem_err      = r_mem_err;
    // Branch bits riding on a memory op are not acted upon.
    assign pcSrc        = r_exmem.valid & r_exmem.branch & r_exmem.aluZero
                        & ~w_memop & ~w_stall;
    assign branchTarget = r_exmem.adder2;

    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_retire     (~w_stall),
        .i_abort      (w_abort),
        .i_load_rdata (w_load_rdata),
        .i_valid      (r_exmem.valid),
        .i_regWrite   (r_exmem.regWrite),
        .i_memtoReg   (r_exmem.memtoReg),
        .i_aluResult  (r_exmem.aluResult),
        .i_writeReg   (r_exmem.writeReg),
        .i_rdata      (dmem_rdata),
        .o_wb_valid   (wb_valid),
        .o_regWrite   (regWrite4),
        .o_memtoReg   (memtoReg4),
        .o_aluResult  (aluResult4),
        .o_memData    (memData4),
        .o_writeReg   (writeReg4)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, corner sequences, and
// randomized traffic against a transaction-level reference model.
module tb_mem_stage;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, regWrite3, memtoReg3, memWrite3, memRead3, branch3;
    logic [15:0] adder2;
    logic        aluZero;
    logic [15:0] aluResult, rdData2_3;
    logic [2:0]  mux3Out;
    logic        stall, pcSrc;
    logic [15:0] branchTarget;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid, regWrite4, memtoReg4;
    logic [15:0] aluResult4, memData4;
    logic [2:0]  writeReg4;
    logic        mem_err;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .regWrite3(regWrite3), .memtoReg3(memtoReg3), .memWrite3(memWrite3),
        .memRead3(memRead3), .branch3(branch3), .adder2(adder2),
        .aluZero(aluZero), .aluResult(aluResult), .rdData2_3(rdData2_3),
        .mux3Out(mux3Out), .stall(stall), .pcSrc(pcSrc),
        .branchTarget(branchTarget), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
        .regWrite4(regWrite4), .memtoReg4(memtoReg4),
        .aluResult4(aluResult4), .memData4(memData4),
        .writeReg4(writeReg4), .mem_err(mem_err)
    );

    typedef struct {
        logic        valid, rw, m2r, mw, mr, br, zero;
        logic [15:0] adder, alu, wdata;
        logic [2:0]  rd;
    } instr_t;

    typedef struct {
        instr_t      in;
        logic        e_pc;
        logic [15:0] e_tgt;
        logic        e_wbv, e_rw4;
        logic [15:0] e_alu4;
        logic [2:0]  e_rd4;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic instr_t bubble();
        instr_t x;
        x = '{valid:0, rw:0, m2r:0, mw:0, mr:0, br:0, zero:0, adder:0, alu:0, wdata:0, rd:0};
        return x;
    endfunction

    task automatic drive(input instr_t x);
        ex_valid  = x.valid; regWrite3 = x.rw; memtoReg3 = x.m2r;
        memWrite3 = x.mw;    memRead3  = x.mr; branch3   = x.br;
        aluZero   = x.zero;  adder2    = x.adder;
        aluResult = x.alu;   rdData2_3 = x.wdata; mux3Out = x.rd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(bubble());
        dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model: the instruction currently held in MEM, how long it
    // has waited, and the writeback record it will produce.
    instr_t      m_inst;
    int          m_wait;
    logic        m_wbv, m_rw4, m_m2r4, m_err;
    logic [15:0] m_alu4, m_mem4;
    logic [2:0]  m_rd4;

    task automatic model_reset();
        m_inst = bubble(); m_wait = 0;
        m_wbv = 0; m_rw4 = 0; m_m2r4 = 0; m_err = 0;
        m_alu4 = 0; m_mem4 = 0; m_rd4 = 0;
    endtask

    function automatic logic is_mem(input instr_t x);
        return x.valid && (x.mr || x.mw);
    endfunction

    function automatic logic exp_stall(input instr_t x, input int waited, input logic ack);
        return is_mem(x) && !ack && (waited < TO - 1);
    endfunction

    vec_t   vecs[5];
    instr_t ld, st, nx;

    initial begin
        vecs[0] = '{in:'{valid:1, rw:1, m2r:0, mw:0, mr:0, br:0, zero:0, adder:16'h0000, alu:16'h1234, wdata:0, rd:3'd5},
                    e_pc:0, e_tgt:16'h0000, e_wbv:1, e_rw4:1, e_alu4:16'h1234, e_rd4:3'd5};
        vecs[1] = '{in:'{valid:1, rw:0, m2r:0, mw:0, mr:0, br:1, zero:1, adder:16'h0100, alu:16'h0000, wdata:0, rd:3'd0},
                    e_pc:1, e_tgt:16'h0100, e_wbv:1, e_rw4:0, e_alu4:16'h0000, e_rd4:3'd0};
        vecs[2] = '{in:'{valid:1, rw:0, m2r:0, mw:0, mr:0, br:1, zero:0, adder:16'h0100, alu:16'h0001, wdata:0, rd:3'd1},
                    e_pc:0, e_tgt:16'h0100, e_wbv:1, e_rw4:0, e_alu4:16'h0001, e_rd4:3'd1};
        vecs[3] = '{in:'{valid:0, rw:1, m2r:0, mw:0, mr:0, br:1, zero:1, adder:16'h0200, alu:16'h5555, wdata:0, rd:3'd7},
                    e_pc:0, e_tgt:16'h0200, e_wbv:0, e_rw4:1, e_alu4:16'h5555, e_rd4:3'd7};
        vecs[4] = '{in:'{valid:1, rw:1, m2r:0, mw:0, mr:0, br:0, zero:1, adder:16'h0300, alu:16'hFFFF, wdata:0, rd:3'd3},
                    e_pc:0, e_tgt:16'h0300, e_wbv:1, e_rw4:1, e_alu4:16'hFFFF, e_rd4:3'd3};

        do_reset();
        @(negedge clk);
        check("rst_stall", stall, 0);      check("rst_pcSrc", pcSrc, 0);
        check("rst_req", dmem_req, 0);     check("rst_wbv", wb_valid, 0);
        check("rst_err", mem_err, 0);      check("rst_alu4", aluResult4, 0);
        check("rst_mem4", memData4, 0);    check("rst_tgt", branchTarget, 0);

        // Single-cycle instructions from the vector table.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].in);
            @(posedge clk); #1 drive(bubble());
            @(negedge clk);
            check($sformatf("v%0d_pcSrc", i), pcSrc, vecs[i].e_pc);
            check($sformatf("v%0d_tgt", i), branchTarget, vecs[i].e_tgt);
            check($sformatf("v%0d_stall", i), stall, 0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_pc_off", i), pcSrc, 0);
            check($sformatf("v%0d_wbv", i), wb_valid, vecs[i].e_wbv);
            check($sformatf("v%0d_rw4", i), regWrite4, vecs[i].e_rw4);
            check($sformatf("v%0d_alu4", i), aluResult4, vecs[i].e_alu4);
            check($sformatf("v%0d_rd4", i), writeReg4, vecs[i].e_rd4);
            $display("vector %0d applied", i);
        end

        // Load with ack in the third ACCESS cycle.
        ld = bubble(); ld.valid = 1; ld.mr = 1; ld.m2r = 1; ld.rw = 1; ld.alu = 16'h0040; ld.rd = 3'd2;
        drive(ld);
        @(posedge clk); #1 drive(bubble()); dmem_ack = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin dmem_ack = 1; dmem_rdata = 16'hBEEF; end
            @(negedge clk);
            check($sformatf("ld_req%0d", c), dmem_req, 1);
            check($sformatf("ld_addr%0d", c), dmem_addr, 16'h0040);
            check($sformatf("ld_stall%0d", c), stall, (c < 2) ? 1 : 0);
            if (c < 2) check($sformatf("ld_bubble%0d", c), wb_valid, 0);
            @(posedge clk); #1;
        end
        dmem_ack = 0;
        @(negedge clk);
        check("ld_wbv", wb_valid, 1);  check("ld_mem4", memData4, 16'hBEEF);
        check("ld_m2r4", memtoReg4, 1); check("ld_req_off", dmem_req, 0);
        $display("load sequence done");

        // Back-to-back store then load, both acked immediately.
        st = bubble(); st.valid = 1; st.mw = 1; st.alu = 16'h0010; st.wdata = 16'h00AA;
        ld = bubble(); ld.valid = 1; ld.mr = 1; ld.rw = 1; ld.alu = 16'h0012; ld.rd = 3'd4;
        drive(st);
        @(posedge clk); #1 drive(ld); dmem_ack = 1; dmem_rdata = 16'h2468;
        @(negedge clk);
        check("b2b_req0", dmem_req, 1);   check("b2b_addr0", dmem_addr, 16'h0010);
        check("b2b_we0", dmem_we, 1);     check("b2b_wd0", dmem_wdata, 16'h00AA);
        check("b2b_stall0", stall, 0);
        @(posedge clk); #1 drive(bubble()); dmem_ack = 1; dmem_rdata = 16'h1357;
        @(negedge clk);
        check("b2b_req1", dmem_req, 1);   check("b2b_addr1", dmem_addr, 16'h0012);
        check("b2b_we1", dmem_we, 0);     check("b2b_stall1", stall, 0);
        check("b2b_st_wbv", wb_valid, 1);
        @(posedge clk); #1 dmem_ack = 0;
        @(negedge clk);
        check("b2b_req2", dmem_req, 0);   check("b2b_ld_wbv", wb_valid, 1);
        check("b2b_mem4", memData4, 16'h1357); check("b2b_rd4", writeReg4, 4);
        $display("back-to-back sequence done");

        // Load that never gets an ack.
        ld = bubble(); ld.valid = 1; ld.mr = 1; ld.rw = 1; ld.alu = 16'h0080; ld.rd = 3'd6;
        drive(ld);
        @(posedge clk); #1 drive(bubble()); dmem_ack = 0;
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            check($sformatf("to_stall%0d", c), stall, (c < TO - 1) ? 1 : 0);
            check($sformatf("to_req%0d", c), dmem_req, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("to_wbv", wb_valid, 1);   check("to_rw4", regWrite4, 0);
        check("to_mem4", memData4, 0);  check("to_err", mem_err, 1);
        check("to_req_off", dmem_req, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("to_err_sticky", mem_err, 1);
        $display("timeout sequence done");

        // Reset during the second ACCESS cycle; a late ack must be ignored.
        ld = bubble(); ld.valid = 1; ld.mr = 1; ld.rw = 1; ld.alu = 16'h0044; ld.rd = 3'd1;
        drive(ld);
        @(posedge clk); #1 drive(bubble());
        @(negedge clk);
        check("rm_req", dmem_req, 1);
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1; dmem_ack = 1; dmem_rdata = 16'hFFFF;
        @(negedge clk);
        check("rm_req_off", dmem_req, 0); check("rm_stall", stall, 0);
        check("rm_wbv", wb_valid, 0);     check("rm_err", mem_err, 0);
        @(posedge clk); #1 dmem_ack = 0;
        @(negedge clk);
        check("rm_late_wbv", wb_valid, 0); check("rm_late_mem4", memData4, 0);
        $display("reset-mid-access sequence done");

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            logic        ack, es, ab, mm;
            int          div;
            nx = bubble();
            nx.valid = ($urandom_range(3) != 0);
            nx.rw = $urandom_range(1); nx.m2r = $urandom_range(1);
            nx.mr = ($urandom_range(3) == 0); nx.mw = ($urandom_range(4) == 0);
            nx.br = $urandom_range(1); nx.zero = $urandom_range(1);
            nx.adder = 16'($urandom); nx.alu = 16'($urandom);
            nx.wdata = 16'($urandom); nx.rd = 3'($urandom_range(7));
            drive(nx);
            div = ((c / 200) % 2 == 1) ? 7 : 2;
            ack = ($urandom_range(div) == 0);
            dmem_ack = ack; dmem_rdata = 16'($urandom);
            @(negedge clk);
            mm = is_mem(m_inst);
            es = exp_stall(m_inst, m_wait, ack);
            check("r_stall", stall, es);
            check("r_pcSrc", pcSrc, m_inst.valid && m_inst.br && m_inst.zero && !mm && !es);
            check("r_tgt", branchTarget, m_inst.adder);
            check("r_req", dmem_req, mm);
            check("r_we", dmem_we, mm && m_inst.mw);
            check("r_addr", dmem_addr, mm ? m_inst.alu : 16'h0);
            check("r_wdata", dmem_wdata, mm ? m_inst.wdata : 16'h0);
            check("r_wbv", wb_valid, m_wbv);
            check("r_rw4", regWrite4, m_rw4);
            check("r_m2r4", memtoReg4, m_m2r4);
            check("r_alu4", aluResult4, m_alu4);
            check("r_mem4", memData4, m_mem4);
            check("r_rd4", writeReg4, m_rd4);
            check("r_err", mem_err, m_err);
            @(posedge clk);
            if (es) begin
                m_wbv = 0;
                m_wait++;
            end else begin
                ab = mm && !ack;
                m_wbv = m_inst.valid; m_rw4 = m_inst.rw && !ab; m_m2r4 = m_inst.m2r;
                m_alu4 = m_inst.alu;  m_rd4 = m_inst.rd;
                if (ab) m_mem4 = 16'h0;
                else if (mm && m_inst.mr && !m_inst.mw) m_mem4 = dmem_rdata;
                if (ab) m_err = 1;
                m_inst = nx;
                m_wait = 0;
            end
            #1;
        end
        $display("random phase done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
